wb_ctrl_pipe: RTL and testbench
===============================

Name: wb_ctrl_pipe

Overview:
- Registered, parametrised writeback-select and control stage for the 9-bit ISA; sits between execute/memory and the register file.
- Chooses the register write value per opcode: ALU result, memory load, nibble-merge immediate or zero-extended move.
- Generates the register-file write enable.
- Sequences `ldb` as a request/valid memory transaction, with back-pressure to fetch and a bounded timeout.

Parameters:
- W, 8: datapath width. Must be at least 8.
- TIMEOUT, 16: maximum number of cycles spent waiting for load data. Must be at least 1.
- NOWB_MASK, 16'h0000: bit k set means opcode k (Instruction[8:5]) performs no register write, e.g. store or branch.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- Instruction  in  9  machine code; opcode is [8:5].
- InstrValid  in  1  instruction offered this cycle.
- InstrReady  out  1  stage can accept an instruction.
- ALU_out  in  W  ALU result for the offered instruction.
- RegReadValue  in  W  current destination-register value, used by ldh/ldl merge.
- MemReadReq  out  1  one-cycle load request pulse.
- MemReadValue  in  W  load data.
- MemReadValid  in  1  MemReadValue is valid.
- RegWrite  out  1  register-file write enable.
- RegWriteValue  out  W  register-file write data.
- MemTimeout  out  1  sticky flag: a load timed out.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - state=IDLE, counter=0.
  - RegWrite=0, RegWriteValue=0, MemReadReq=0, MemTimeout=0.
  - A reset mid-load abandons the load; any later MemReadValid is ignored.
- Handshake:
  - InstrReady = (state==IDLE); this is combinational from state only.
  - accept = InstrValid & InstrReady.
- Value select, evaluated on the accepted cycle N:
  - opcode 4'b1010 (ldl): value = {RegReadValue[W-1:4], Instruction[4:1]}.
  - opcode 4'b1011 (ldh): value = {RegReadValue[W-1:8], Instruction[4:1], RegReadValue[3:0]}.
  - opcode 4'b0111 (mov): value = Instruction[4:0] zero-extended to W.
  - any other opcode except 4'b1000: value = ALU_out.
- Non-load accepted at cycle N:
  - Cycle N+1: RegWrite = ~NOWB_MASK[opcode], RegWriteValue = the selected value.
  - When NOWB_MASK[opcode] is set: RegWrite=0 and RegWriteValue holds its previous value.
  - Back-to-back instructions give one write per cycle.
- Load (opcode 4'b1000) accepted at cycle N:
  - Cycle N+1: MemReadReq=1 for exactly one cycle, RegWrite=0.
  - state becomes WAIT_MEM and counter clears.
- WAIT_MEM, evaluated each cycle:
  - MemReadValid=1 (this may coincide with the MemReadReq cycle): next cycle RegWrite=1 and RegWriteValue=MemReadValue, then state=IDLE. The NOWB_MASK bit for opcode 8 is ignored.
  - MemReadValid=0 and counter==TIMEOUT-1: next cycle state=IDLE, MemTimeout=1, RegWrite=0.
  - otherwise counter increments.
  - State is in WAIT_MEM for at most TIMEOUT cycles.
  - counter width is clog2(TIMEOUT+1).
- Stray MemReadValid while IDLE is ignored.
- RegWrite is 0 in every cycle not listed above.
- MemTimeout clears only on reset.
- InstrValid=0 produces no writes, and outputs other than RegWrite hold their values.

Decomposition:
- Package wb_ctrl_pkg holds:
  - opcode constants OP_LDB=4'b1000, OP_LDL=4'b1010, OP_LDH=4'b1011, OP_MOV=4'b0111;
  - state enum {IDLE, WAIT_MEM};
  - a width-check function for W.
- One combinational sub-module, wb_value_sel:
  - inputs: opcode, Instruction[4:0], ALU_out, RegReadValue;
  - output: the W-bit value.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset low for 2 cycles with InstrValid=1 -> RegWrite=0, MemReadReq=0, MemTimeout=0, RegWriteValue=0, InstrReady=1 after release.
- mov 9'b0111_10101, then an add opcode with ALU_out=8'h3C on the next cycle -> RegWrite=1 with value 8'h15, then 8'h3C, on consecutive cycles.
- ldl imm=4'hA with RegReadValue=8'h5F -> 8'h5A; ldh imm=4'h3 with RegReadValue=8'h5F -> 8'h3F; W=16, ldh imm=4'h3, RegReadValue=16'hABCD -> 16'hAB3D.
- ldb, MemReadValid raised 3 cycles after MemReadReq with MemReadValue=8'hE7:
  - InstrReady=0 throughout the wait, with an instruction held on InstrValid;
  - RegWrite=1 with 8'hE7 on the following cycle;
  - the held instruction is accepted the cycle after that.
- ldb with MemReadValid never raised, TIMEOUT=4 -> exactly 4 WAIT_MEM cycles, RegWrite stays 0, MemTimeout=1 and sticky; a later stray valid is ignored.
- NOWB_MASK=16'h0004, opcode 2 accepted -> RegWrite=0; Reset pulled low during WAIT_MEM -> IDLE next cycle and the late MemReadValid is ignored.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: opcodes, stage states and parameter checks for the writeback/control stage
package wb_ctrl_pkg;
  localparam logic [3:0] OP_LDB = 4'b1000;
  localparam logic [3:0] OP_LDL = 4'b1010;
  localparam logic [3:0] OP_LDH = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b0111;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  function automatic bit width_ok(int w);
    return w >= 8;
  endfunction
endpackage

// File: rtl/wb_value_sel.sv
// wb_value_sel: per-opcode register write value (ALU, nibble merge, zero-extended move)
module wb_value_sel import wb_ctrl_pkg::*; #(
  parameter int W = 8
) (
  input  logic [3:0]   opcode,
  input  logic [4:0]   imm,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] reg_read_value,
  output logic [W-1:0] value
);
  // Masked merges keep W=8 legal where a [W-1:8] slice would not be
  always_comb
    value = opcode == OP_LDL ? (reg_read_value & ~W'(8'h0F)) | W'(imm[4:1]) :
            opcode == OP_LDH ? (reg_read_value & ~W'(8'hF0)) | (W'(imm[4:1]) << 4) :
            opcode == OP_MOV ? W'(imm) :
            alu_out;
endmodule

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: registered writeback select, register write enable and bounded load sequencing
module wb_ctrl_pipe import wb_ctrl_pkg::*; #(
  parameter int          W         = 8,
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] NOWB_MASK = 16'h0000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [8:0]   Instruction,
  input  logic         InstrValid,
  output logic         InstrReady,
  input  logic [W-1:0] ALU_out,
  input  logic [W-1:0] RegReadValue,
  output logic         MemReadReq,
  input  logic [W-1:0] MemReadValue,
  input  logic         MemReadValid,
  output logic         RegWrite,
  output logic [W-1:0] RegWriteValue,
  output logic         MemTimeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  if (!width_ok(W) || TIMEOUT < 1) begin : g_param_err
    $fatal(1, "wb_ctrl_pipe: W must be >= 8 and TIMEOUT >= 1");
  end
  state_t       state;
  logic [CW-1:0] cnt;
  logic [3:0]   op;
  logic [W-1:0] val;
  logic         accept;
  assign op         = Instruction[8:5];
  assign InstrReady = state == IDLE;
  assign accept     = InstrValid & InstrReady;
  wb_value_sel #(.W(W)) u_sel (
    .opcode         (op),
    .imm            (Instruction[4:0]),
    .alu_out        (ALU_out),
    .reg_read_value (RegReadValue),
    .value          (val)
  );
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      RegWrite      <= 1'b0;
      RegWriteValue <= '0;
      MemReadReq    <= 1'b0;
      MemTimeout    <= 1'b0;
    end else begin
      RegWrite   <= 1'b0;
      MemReadReq <= 1'b0;
      if (state == IDLE) begin
        if (accept && op == OP_LDB) begin
          MemReadReq <= 1'b1;
          state      <= WAIT_MEM;
          cnt        <= '0;
        end else if (accept) begin
          RegWrite <= ~NOWB_MASK[op];
          if (!NOWB_MASK[op]) RegWriteValue <= val;
        end
      end else if (MemReadValid) begin
        RegWrite      <= 1'b1;
        RegWriteValue <= MemReadValue;
        state         <= IDLE;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        MemTimeout <= 1'b1;
        state      <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// tb_wb_ctrl_pipe: table-driven and sequenced checks of the writeback/control stage
module tb_wb_ctrl_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  instr;
  logic        ivalid;
  logic [7:0]  alu, rr, mrv;
  logic        mvalid;
  logic        ready, req, we, tmo;
  logic [7:0]  wval;
  logic [15:0] alu16, rr16, mrv16, wval16;
  logic        ready16, req16, we16, tmo16;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    logic       valid;
    logic [8:0] instr;
    logic [7:0] alu;
    logic [7:0] rr;
    logic       we;
    logic [7:0] val;
  } vec_t;
  vec_t vec[9];
  always #5 clk = ~clk;
  wb_ctrl_pipe #(.W(8), .TIMEOUT(4), .NOWB_MASK(16'h0004)) dut (
    .Clk(clk), .Reset(reset), .Instruction(instr), .InstrValid(ivalid), .InstrReady(ready),
    .ALU_out(alu), .RegReadValue(rr), .MemReadReq(req), .MemReadValue(mrv),
    .MemReadValid(mvalid), .RegWrite(we), .RegWriteValue(wval), .MemTimeout(tmo)
  );
  wb_ctrl_pipe #(.W(16)) dut16 (
    .Clk(clk), .Reset(reset), .Instruction(instr), .InstrValid(ivalid), .InstrReady(ready16),
    .ALU_out(alu16), .RegReadValue(rr16), .MemReadReq(req16), .MemReadValue(mrv16),
    .MemReadValid(mvalid), .RegWrite(we16), .RegWriteValue(wval16), .MemTimeout(tmo16)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    vec[0] = '{1'b1, 9'b0111_10101, 8'h00, 8'h00, 1'b1, 8'h15};
    vec[1] = '{1'b1, 9'b0000_00000, 8'h3C, 8'h00, 1'b1, 8'h3C};
    vec[2] = '{1'b1, 9'b1010_10100, 8'h00, 8'h5F, 1'b1, 8'h5A};
    vec[3] = '{1'b1, 9'b1011_00110, 8'h00, 8'h5F, 1'b1, 8'h3F};
    vec[4] = '{1'b1, 9'b0010_00000, 8'h77, 8'h00, 1'b0, 8'h3F};
    vec[5] = '{1'b0, 9'b0001_00000, 8'h55, 8'h00, 1'b0, 8'h3F};
    vec[6] = '{1'b1, 9'b0001_00000, 8'h99, 8'h00, 1'b1, 8'h99};
    vec[7] = '{1'b1, 9'b0111_11111, 8'h00, 8'h00, 1'b1, 8'h1F};
    vec[8] = '{1'b1, 9'b1010_00001, 8'h00, 8'hFF, 1'b1, 8'hF0};
    alu16 = 16'h0000; rr16 = 16'hABCD; mrv16 = 16'h0000;
    alu = 8'h00; rr = 8'h00; mrv = 8'h00; mvalid = 1'b0;
    reset = 1'b0; ivalid = 1'b1; instr = 9'b0111_10101;
    step(); step();
    chk("rst_we", we, 0);
    chk("rst_req", req, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_val", wval, 0);
    chk("rst_ready", ready, 1);
    reset = 1'b1; ivalid = 1'b0;
    step();
    chk("idle_we", we, 0);
    for (int i = 0; i < 9; i++) begin
      ivalid = vec[i].valid; instr = vec[i].instr; alu = vec[i].alu; rr = vec[i].rr;
      step();
      chk($sformatf("vec%0d_we", i), we, vec[i].we);
      chk($sformatf("vec%0d_val", i), wval, vec[i].val);
      if (i == 3) chk("w16_ldh_val", wval16, 16'hAB3D);
    end
    ivalid = 1'b1; instr = 9'b1000_00000;
    step();
    chk("ld_req", req, 1);
    chk("ld_req_we", we, 0);
    chk("ld_req_ready", ready, 0);
    instr = 9'b0000_00000; alu = 8'h42;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("ld_wait%0d_ready", c), ready, 0);
      chk($sformatf("ld_wait%0d_req", c), req, 0);
      chk($sformatf("ld_wait%0d_we", c), we, 0);
    end
    mvalid = 1'b1; mrv = 8'hE7;
    step();
    chk("ld_data_we", we, 1);
    chk("ld_data_val", wval, 8'hE7);
    chk("ld_data_ready", ready, 1);
    chk("ld_data_tmo", tmo, 0);
    mvalid = 1'b0;
    step();
    chk("ld_held_we", we, 1);
    chk("ld_held_val", wval, 8'h42);
    instr = 9'b1000_00000;
    step();
    chk("co_req", req, 1);
    ivalid = 1'b0; mvalid = 1'b1; mrv = 8'hC3;
    step();
    chk("co_we", we, 1);
    chk("co_val", wval, 8'hC3);
    chk("co_ready", ready, 1);
    chk("co_req_low", req, 0);
    mvalid = 1'b0; ivalid = 1'b1; instr = 9'b1000_00000;
    step();
    ivalid = 1'b0;
    begin
      int n;
      n = 0;
      while (!ready && n < 10) begin
        chk("to_wait_we", we, 0);
        n++;
        step();
      end
      chk("to_wait_cycles", n, 4);
    end
    chk("to_tmo", tmo, 1);
    chk("to_we", we, 0);
    mvalid = 1'b1; mrv = 8'h11;
    step();
    chk("stray_we", we, 0);
    chk("stray_val", wval, 8'hC3);
    chk("stray_ready", ready, 1);
    mvalid = 1'b0;
    step();
    chk("to_sticky", tmo, 1);
    ivalid = 1'b1; instr = 9'b1000_00000;
    step();
    ivalid = 1'b0;
    step();
    chk("mr_wait_ready", ready, 0);
    reset = 1'b0;
    step();
    chk("mr_ready", ready, 1);
    chk("mr_req", req, 0);
    chk("mr_tmo", tmo, 0);
    chk("mr_we", we, 0);
    reset = 1'b1; mvalid = 1'b1; mrv = 8'hAA;
    step();
    chk("mr_late_we", we, 0);
    chk("mr_late_val", wval, 0);
    mvalid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
